// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake with a
// one-entry hold buffer for stalls, and loads the IF/ID pipeline register.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_load,
   input  logic        if_id_write,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;

   logic        advance;
   logic [31:0] flush_pc;
   logic [31:0] pc_plus4;
   logic [31:0] addr_plus4;

   assign advance    = pc_load & if_id_write;
   assign flush_pc   = {redirect_pc[31:2], 2'b00};
   assign pc_plus4   = pc_q + 32'd4;
   assign addr_plus4 = addr_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;

      case (state_q)
         FETCH: begin
            if (flush) begin
               pc_d    = flush_pc;
               instr_d = 32'd0;
               pc4_d   = 32'd0;
               valid_d = 1'b0;
               if (imem_ready) begin
                  addr_d = flush_pc;
               end else begin
                  state_d = DRAIN;
               end
            end else if (imem_ready) begin
               if (advance) begin
                  instr_d = imem_rdata;
                  pc4_d   = addr_plus4;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4;
                  addr_d  = pc_plus4;
               end else begin
                  buf_instr_d = imem_rdata;
                  buf_pc4_d   = addr_plus4;
                  state_d     = HOLD;
               end
            end else if (if_id_write) begin
               instr_d = 32'd0;
               pc4_d   = 32'd0;
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d    = flush_pc;
               addr_d  = flush_pc;
               instr_d = 32'd0;
               pc4_d   = 32'd0;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (advance) begin
               instr_d = buf_instr_q;
               pc4_d   = buf_pc4_q;
               valid_d = 1'b1;
               pc_d    = pc_plus4;
               addr_d  = pc_plus4;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            // The abandoned address stays on the bus until memory answers it.
            if (flush) begin
               pc_d    = flush_pc;
               instr_d = 32'd0;
               pc4_d   = 32'd0;
               valid_d = 1'b0;
            end
            if (imem_ready) begin
               addr_d  = pc_d;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
            addr_d  = pc_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         instr_q     <= 32'd0;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
         buf_instr_q <= 32'd0;
         buf_pc4_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
      end
   end

   assign imem_req    = ~rst & (state_q != HOLD);
   assign imem_addr   = addr_q;
   assign pc          = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised self-checking bench for if_fetch_stage against a behavioural
// model of the fetch rules, preceded by directed scenarios.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        pc_load;
   logic        if_id_write;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   logic [31:0] rdataNoise;
   int          checkCount;
   int          errorCount;

   // Behavioural model state
   logic [31:0] mPc, mAddr, mInstr, mPc4, mBufI, mBufP;
   logic        mValid, mHold, mDrain;

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .pc_load(pc_load), .if_id_write(if_id_write),
      .flush(flush), .redirect_pc(redirect_pc), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a ^ {a[15:0], a[31:16]}) ^ 32'hC0DE_0001;
   endfunction

   // Memory answers with the word at the presented address, noise otherwise.
   assign imem_rdata = imem_ready ? memWord(imem_addr) : rdataNoise;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPc = 32'd0; mAddr = 32'd0; mInstr = 32'd0; mPc4 = 32'd0;
      mBufI = 32'd0; mBufP = 32'd0; mValid = 1'b0; mHold = 1'b0; mDrain = 1'b0;
   endtask

   task automatic modelStep(input logic pl, input logic iw, input logic fl,
                            input logic [31:0] rp, input logic rdy);
      logic busy;
      logic adv;
      busy = !mHold;
      adv  = pl && iw;
      if (fl) begin
         mPc = rp & 32'hFFFF_FFFC;
         mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0;
         mHold  = 1'b0;
         mDrain = busy && !rdy;
      end else if (mDrain) begin
         if (rdy) mDrain = 1'b0;
      end else if (mHold) begin
         if (adv) begin
            mInstr = mBufI; mPc4 = mBufP; mValid = 1'b1;
            mPc = mPc + 32'd4; mHold = 1'b0;
         end
      end else if (rdy) begin
         if (adv) begin
            mInstr = memWord(mAddr); mPc4 = mAddr + 32'd4; mValid = 1'b1;
            mPc = mPc + 32'd4;
         end else begin
            mBufI = memWord(mAddr); mBufP = mAddr + 32'd4; mHold = 1'b1;
         end
      end else if (iw) begin
         mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0;
      end
      // An unanswered request keeps its address; any new request starts at pc.
      if (!(busy && !rdy)) mAddr = mPc;
   endtask

   task automatic applyStimulus(input logic pl, input logic iw, input logic fl,
                                input logic [31:0] rp, input logic rdy);
      pc_load = pl; if_id_write = iw; flush = fl; redirect_pc = rp; imem_ready = rdy;
      rdataNoise = $urandom;
   endtask

   // One clock cycle: drive, check request side, clock, then check IF/ID side.
   task automatic doCycle(input logic pl, input logic iw, input logic fl,
                          input logic [31:0] rp, input logic rdy);
      applyStimulus(pl, iw, fl, rp, rdy);
      #1;
      checkOutput("req", {31'd0, imem_req}, {31'd0, !mHold});
      if (!mHold) checkOutput("addr", imem_addr, mAddr);
      @(posedge clk);
      #1;
      modelStep(pl, iw, fl, rp, rdy);
      checkOutput("pc", pc, mPc);
      checkOutput("instr", if_id_instr, mInstr);
      checkOutput("pc4", if_id_pc4, mPc4);
      checkOutput("valid", {31'd0, if_id_valid}, {31'd0, mValid});
   endtask

   task automatic pulseReset();
      #2 rst = 1'b1;
      #1;
      checkOutput("rstPc", pc, 32'd0);
      checkOutput("rstInstr", if_id_instr, 32'd0);
      checkOutput("rstPc4", if_id_pc4, 32'd0);
      checkOutput("rstValid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
      checkOutput("rstAddr", imem_addr, 32'd0);
      modelReset();
      #2 rst = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      modelReset();
      #2;
      checkOutput("resetReq", {31'd0, imem_req}, 32'd0);
      checkOutput("resetPc", pc, 32'd0);
      #21 rst = 1'b0;

      // Zero-wait streaming
      for (int i = 0; i < 5; i++) begin
         checkOutput("seqAddr", imem_addr, 32'(4 * i));
         doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
         checkOutput("seqPc4", if_id_pc4, 32'(4 * (i + 1)));
      end

      // Hazard stall while fetching 20
      doCycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("stallPc", pc, 32'd20);
      checkOutput("stallPc4", if_id_pc4, 32'd20);
      checkOutput("holdReq", {31'd0, imem_req}, 32'd0);
      doCycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("stallPc2", pc, 32'd20);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("releasePc4", if_id_pc4, 32'd24);
      checkOutput("releaseInstr", if_id_instr, memWord(32'd20));

      // Two wait states on address 24
      for (int i = 0; i < 2; i++) begin
         checkOutput("waitAddr", imem_addr, 32'd24);
         doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
         checkOutput("waitValid", {31'd0, if_id_valid}, 32'd0);
         checkOutput("waitInstr", if_id_instr, 32'd0);
      end
      checkOutput("waitAddr3", imem_addr, 32'd24);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("waitDonePc4", if_id_pc4, 32'd28);

      // Flush with zero-wait memory
      doCycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
      checkOutput("flushValid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("flushAddr", imem_addr, 32'h100);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("flushTgtPc4", if_id_pc4, 32'h104);

      // Flush during a wait state drains the old request
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      doCycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
      checkOutput("drainAddr", imem_addr, 32'h104);
      checkOutput("drainReq", {31'd0, imem_req}, 32'd1);
      checkOutput("drainPc", pc, 32'h200);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("drainDiscard", {31'd0, if_id_valid}, 32'd0);
      checkOutput("drainNextAddr", imem_addr, 32'h200);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("drainTgtPc4", if_id_pc4, 32'h204);

      // Wrap-around of the PC, low target bits ignored
      doCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
      checkOutput("wrapPre", pc, 32'hFFFF_FFFC);
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("wrapPc", pc, 32'd0);
      checkOutput("wrapPc4", if_id_pc4, 32'd0);

      // Async reset in the middle of a wait state
      doCycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      pulseReset();

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         logic        pl, iw, fl, rdy;
         logic [31:0] rp;
         int          sel;
         sel = int'($urandom_range(0, 9));
         pl  = 1'b1;
         iw  = 1'b1;
         if (sel < 2) begin
            pl = 1'b0; iw = 1'b0;
         end else if (sel == 2) begin
            pl = $urandom_range(0, 1) == 1;
            iw = !pl;
         end
         fl  = $urandom_range(0, 11) == 0;
         rdy = $urandom_range(0, 2) != 0;
         rp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
         doCycle(pl, iw, fl, rp, rdy);
         if (i % 500 == 250) pulseReset();
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
